// File: rtl/pll_lock_supervisor.sv
// Sequences PLL power-up, waits for a qualified lock, and holds the fabric in
// reset until lock has been stable long enough. It also counts lock losses and timeouts.
module pll_lock_supervisor #(
  parameter int unsigned POWERDOWN_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PLL_LOCK,
  input  logic       Relock_Req,
  output logic       PLL_POWERDOWN_N,
  output logic       Fabric_Reset,
  output logic       Ready,
  output logic [7:0] Lost_Count,
  output logic [7:0] Timeout_Count,
  output logic [1:0] State
);

  localparam logic [1:0] ST_POWERDOWN = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam logic [15:0] PD_LAST      = 16'(POWERDOWN_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);

  logic        sync1_q, sync1_d;
  logic        lock_s_q, lock_s_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lost_q, lost_d;
  logic [7:0]  timeout_q, timeout_d;
  logic        pd_n_q, pd_n_d;
  logic        fab_rst_q, fab_rst_d;
  logic        ready_q, ready_d;

  // Raw lock is asynchronous; only the second synchroniser stage feeds the FSM.
  always_comb begin
    sync1_d  = PLL_LOCK;
    lock_s_d = sync1_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    lost_d    = lost_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_POWERDOWN: begin
        if (Relock_Req) begin
          cnt_d = 16'd0;
        end else if (cnt_q == PD_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (Relock_Req) begin
          state_d = ST_POWERDOWN;
        end else if (lock_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_POWERDOWN;
          timeout_d = (timeout_q == 8'hFF) ? timeout_q : timeout_q + 8'd1;
        end
      end
      ST_STABLE: begin
        if (Relock_Req) begin
          state_d = ST_POWERDOWN;
        end else if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // The counter has no job in RUN; hold it rather than let it wrap.
        cnt_d = cnt_q;
        // A loss is counted even when a relock request arrives on the same cycle.
        if (!lock_s_q) begin
          lost_d = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end
        if (Relock_Req || !lock_s_q) begin
          state_d = ST_POWERDOWN;
        end
      end
      default: begin
        state_d = ST_POWERDOWN;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end
  end

  // Outputs are decoded from the next state so each registered output
  // changes on the same edge as the state it describes.
  always_comb begin
    pd_n_d    = (state_d != ST_POWERDOWN);
    fab_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= ST_POWERDOWN;
      cnt_q     <= 16'd0;
      lost_q    <= 8'd0;
      timeout_q <= 8'd0;
      pd_n_q    <= 1'b0;
      fab_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      lock_s_q  <= lock_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      timeout_q <= timeout_d;
      pd_n_q    <= pd_n_d;
      fab_rst_q <= fab_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign Fabric_Reset    = fab_rst_q;
  assign Ready           = ready_q;
  assign Lost_Count      = lost_q;
  assign Timeout_Count   = timeout_q;
  assign State           = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with POWERDOWN=4, TIMEOUT=20, STABLE=8.
// PLL_LOCK is modelled as lock_en gated by power, because a powered-down PLL cannot report lock.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       lock_en;
  logic       pll_lock;
  logic       relock_req;
  logic       pd_n;
  logic       fab_rst;
  logic       ready;
  logic [7:0] lost_count;
  logic [7:0] timeout_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_PD = 2'd0;
  localparam logic [1:0] S_WL = 2'd1;
  localparam logic [1:0] S_ST = 2'd2;
  localparam logic [1:0] S_RN = 2'd3;

  assign pll_lock = lock_en & pd_n;

  pll_lock_supervisor #(
    .POWERDOWN_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .STABLE_CYCLES      (8)
  ) dut (
    .Clock          (clk),
    .Reset          (rst),
    .PLL_LOCK       (pll_lock),
    .Relock_Req     (relock_req),
    .PLL_POWERDOWN_N(pd_n),
    .Fabric_Reset   (fab_rst),
    .Ready          (ready),
    .Lost_Count     (lost_count),
    .Timeout_Count  (timeout_count),
    .State          (state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag, input logic [7:0] exp_lost,
                                  input logic [7:0] exp_to);
    chk({tag, "_state"}, 32'(state), 32'(S_PD));
    chk({tag, "_pd_n"}, 32'(pd_n), 32'd0);
    chk({tag, "_fab_rst"}, 32'(fab_rst), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_lost"}, 32'(lost_count), 32'(exp_lost));
    chk({tag, "_timeout"}, 32'(timeout_count), 32'(exp_to));
  endtask

  initial begin
    rst        = 1'b1;
    relock_req = 1'b0;
    lock_en    = 1'b1;
    step(2);
    chk_reset_values("por", 8'd0, 8'd0);

    // Clean start: reset released just after edge 0.
    rst = 1'b0;
    step(3);
    chk("cs_pd_low_e3", 32'(pd_n), 32'd0);
    step(1);
    chk("cs_pd_high_e4", 32'(pd_n), 32'd1);
    chk("cs_wait_e4", 32'(state), 32'(S_WL));
    step(2);
    chk("cs_wait_e6", 32'(state), 32'(S_WL));
    step(1);
    chk("cs_stable_e7", 32'(state), 32'(S_ST));
    chk("cs_fab_rst_e7", 32'(fab_rst), 32'd1);
    step(7);
    chk("cs_stable_e14", 32'(state), 32'(S_ST));
    chk("cs_ready_e14", 32'(ready), 32'd0);
    step(1);
    chk("cs_run_e15", 32'(state), 32'(S_RN));
    chk("cs_ready_e15", 32'(ready), 32'd1);
    chk("cs_fab_rst_e15", 32'(fab_rst), 32'd0);
    chk("cs_lost", 32'(lost_count), 32'd0);
    chk("cs_timeout", 32'(timeout_count), 32'd0);

    // Relock in RUN with good lock: powerdown, no loss counted.
    step(1);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    chk("rr_state", 32'(state), 32'(S_PD));
    chk("rr_pd_n", 32'(pd_n), 32'd0);
    chk("rr_fab_rst", 32'(fab_rst), 32'd1);
    chk("rr_ready", 32'(ready), 32'd0);
    chk("rr_lost", 32'(lost_count), 32'd0);
    step(7);
    chk("rr_stable", 32'(state), 32'(S_ST));

    // Glitch: lock_s seen low at stable count 5.
    step(3);
    lock_en = 1'b0;
    step(1);
    lock_en = 1'b1;
    step(1);
    chk("gl_still_stable", 32'(state), 32'(S_ST));
    step(1);
    chk("gl_back_wait", 32'(state), 32'(S_WL));
    step(1);
    chk("gl_restable", 32'(state), 32'(S_ST));
    step(7);
    chk("gl_not_run_yet", 32'(state), 32'(S_ST));
    step(1);
    chk("gl_run", 32'(state), 32'(S_RN));
    chk("gl_lost", 32'(lost_count), 32'd0);
    chk("gl_timeout", 32'(timeout_count), 32'd0);

    // Lock loss in RUN for 3 cycles.
    lock_en = 1'b0;
    step(2);
    chk("ll_run_r2", 32'(state), 32'(S_RN));
    chk("ll_ready_r2", 32'(ready), 32'd1);
    step(1);
    lock_en = 1'b1;
    chk("ll_state", 32'(state), 32'(S_PD));
    chk("ll_fab_rst", 32'(fab_rst), 32'd1);
    chk("ll_ready", 32'(ready), 32'd0);
    chk("ll_lost", 32'(lost_count), 32'd1);
    chk("ll_pd_low_r3", 32'(pd_n), 32'd0);
    step(3);
    chk("ll_pd_low_r6", 32'(pd_n), 32'd0);
    step(1);
    chk("ll_pd_high_r7", 32'(pd_n), 32'd1);
    chk("ll_wait_r7", 32'(state), 32'(S_WL));
    step(11);
    chk("ll_run_again", 32'(state), 32'(S_RN));

    // Relock together with lock_s=0 in RUN, then a second relock at powerdown count 2.
    lock_en = 1'b0;
    step(2);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    lock_en    = 1'b1;
    chk("rl_state", 32'(state), 32'(S_PD));
    chk("rl_lost", 32'(lost_count), 32'd2);
    step(2);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    chk("rl_ext_state", 32'(state), 32'(S_PD));
    step(3);
    chk("rl_pd_low_7th", 32'(pd_n), 32'd0);
    step(1);
    chk("rl_pd_high_8th", 32'(pd_n), 32'd1);
    chk("rl_lost_hold", 32'(lost_count), 32'd2);
    step(11);
    chk("rl_run", 32'(state), 32'(S_RN));

    // Asynchronous reset mid-RUN, observed before the next clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk_reset_values("ar", 8'd0, 8'd0);
    step(1);
    rst = 1'b0;

    // Lock never asserts: 24-cycle timeout period.
    lock_en = 1'b0;
    step(3);
    chk("to_pd_low_e3", 32'(pd_n), 32'd0);
    step(1);
    chk("to_pd_high_e4", 32'(pd_n), 32'd1);
    step(19);
    chk("to_wait_e23", 32'(state), 32'(S_WL));
    chk("to_cnt_e23", 32'(timeout_count), 32'd0);
    step(1);
    chk("to_pd_e24", 32'(state), 32'(S_PD));
    chk("to_pd_n_e24", 32'(pd_n), 32'd0);
    chk("to_cnt_e24", 32'(timeout_count), 32'd1);
    step(3);
    chk("to_pd_low_e27", 32'(pd_n), 32'd0);
    step(1);
    chk("to_pd_high_e28", 32'(pd_n), 32'd1);
    step(43);
    chk("to_cnt_e71", 32'(timeout_count), 32'd2);
    step(1);
    chk("to_cnt_e72", 32'(timeout_count), 32'd3);
    step(24 * 297);
    chk("to_saturated", 32'(timeout_count), 32'd255);
    chk("to_lost_zero", 32'(lost_count), 32'd0);

    // Relock in WAIT_LOCK leaves the saturated timeout count alone.
    step(5);
    chk("rw_wait", 32'(state), 32'(S_WL));
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    chk("rw_pd", 32'(state), 32'(S_PD));
    chk("rw_timeout", 32'(timeout_count), 32'd255);

    // 256 lock losses: Lost_Count must stop at 255.
    lock_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step(15);
      if (i == 0) chk("ls_first_run", 32'(state), 32'(S_RN));
      lock_en = 1'b0;
      step(3);
      lock_en = 1'b1;
    end
    chk("ls_saturated", 32'(lost_count), 32'd255);
    chk("ls_state", 32'(state), 32'(S_PD));

    rst = 1'b1;
    #1;
    chk_reset_values("final_rst", 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
